cmem_loader: RTL and testbench
==============================

# cmem_loader

Write-side controller for the coefficient memory `cmem`. It accepts a stream of 16-bit coefficients over a valid/ready handshake and drives the `cmem` write port (`D`, `WEN`, `CEN`). It fills all `BLKS` × `DEPTH` entries in ascending order: block 0 address 0 first, block `BLKS-1` address `DEPTH-1` last. It also reports progress, completion and a running checksum. It sits between the host/config path and `cmem`, which the FIR datapath then reads through its eight read ports.

## Interface
- `DW`, default 16: coefficient width; matches `cmem` `D`.
- `DEPTH`, default 64: entries per block; matches `cmem` address space (6 bits).
- `BLKS`, default 8: number of blocks; total words `NWORDS = BLKS*DEPTH` = 512.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a load; honoured only in IDLE or DONE.
- `in_valid` in 1: coefficient on `in_data` is valid.
- `in_data` in `DW`: coefficient word.
- `in_ready` out 1: loader accepts a word this cycle; registered.
- `D` out `DW`: write data to `cmem`.
- `WEN` out 1: `cmem` write enable, active-low.
- `CEN` out 1: `cmem` chip enable, active-low.
- `wr_blk` out 3: block index of the word currently on `D`.
- `wr_addr` out 6: address within block of the word currently on `D`.
- `busy` out 1: high in LOAD and DRAIN.
- `done` out 1: high in DONE until the next `start` or `rst`.
- `checksum` out 16: sum of all accepted words, modulo 2^16.

## Operation
- FSM states:
  - IDLE: `in_ready`=0, no writes.
  - LOAD: `in_ready`=1.
  - DRAIN: final write in flight, `in_ready`=0.
  - DONE: `in_ready`=0, `done`=1.
- Transitions:
  - IDLE→LOAD on `start`.
  - DONE→LOAD on `start`. This clears `done`, the word counter and `checksum` at the same edge.
  - LOAD→DRAIN on the edge that accepts word `NWORDS-1`.
  - DRAIN→DONE on the next edge.
  - `start` in LOAD or DRAIN is ignored.
- Beat acceptance: a beat is accepted when `in_valid & in_ready` at a rising edge.
  - `in_valid` while `in_ready`=0 is ignored; no write occurs and no state changes.
- Each accepted beat, at the accepting edge:
  - `D` ← `in_data`, `WEN` ← 0, `CEN` ← 0.
  - `{wr_blk, wr_addr}` ← word counter.
  - The counter increments; it is 9 bits, with `wr_blk` = counter[8:6] and `wr_addr` = counter[5:0].
  - `checksum` ← `checksum` + `in_data`, truncated to 16 bits.
- Any cycle without an accepted beat: `WEN`=1, `CEN`=1 at the following edge. `D`, `wr_blk` and `wr_addr` hold their last values.
- The counter does not wrap during a load; exactly `NWORDS` writes occur per load.
- `rst` mid-load: all outputs return to reset values at the next edge and the FSM returns to IDLE.
  - `cmem` contents already written are left as-is.
  - The next `start` restarts at block 0, address 0.

## Timing
- Reset values:
  - `WEN`=1, `CEN`=1, `D`=0.
  - `wr_blk`=0, `wr_addr`=0.
  - `in_ready`=0, `busy`=0, `done`=0, `checksum`=0.
  - FSM=IDLE, counter=0.
- `start` sampled at edge S: `in_ready`=1 and `busy`=1 from cycle S+1.
- Beat accepted at edge N: `WEN`/`CEN` are low during cycle N+1, and `cmem` commits the word at edge N+1. Write latency is 1 cycle.
- Full rate: with `in_valid` held high, one write per cycle and 512 consecutive low-`WEN` cycles.
- Last beat accepted at edge L:
  - `in_ready` falls in cycle L+1.
  - The final write commits at edge L+1.
  - `done`=1 and `busy`=0 from cycle L+2.
- `checksum` is final once the last beat is accepted (valid from cycle L+1) and holds through DONE.

## Test plan
- Reset check: assert `rst` for 2 cycles with `in_valid`=1 → `WEN`=`CEN`=1, `in_ready`=0, `done`=0, `checksum`=0x0000, and no writes.
- Full-rate load: `start`, then `in_valid`=1 continuously with `in_data`=0..511.
  - 512 consecutive write cycles with `{wr_blk,wr_addr}` = 0..511.
  - `done` rises 2 cycles after the last accept; `checksum`=0xFF00.
  - Reading `cmem` back with random A0..A7 returns 64·blk+addr.
- Bubbles: `in_valid` randomly 50% with `$urandom` data → `WEN` high exactly on non-accept cycles, 512 writes total, and `checksum` matches the model sum mod 2^16.
- Ignored controls:
  - `start` pulsed at word 200 → no restart; the counter continues 201, 202, ….
  - `in_valid`=1 in IDLE or DONE → no write.
  - `start` in DONE → `done` falls and the next write lands at blk 0, addr 0.
- Reset mid-load: `rst` at word 100 → next cycle all outputs are at reset values. A new `start` plus 512 words completes normally with a correct `checksum`.

Source files
------------

// File: rtl/cmem_loader.sv
// cmem_loader: streams BLKS*DEPTH coefficients into cmem in ascending order with progress, done and checksum
module cmem_loader #(
  parameter int DW = 16,
  parameter int DEPTH = 64,
  parameter int BLKS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  output logic [DW-1:0]            D,
  output logic                     WEN,
  output logic                     CEN,
  output logic [$clog2(BLKS)-1:0]  wr_blk,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              checksum
);
  localparam int NWORDS = BLKS * DEPTH;
  localparam int CW = $clog2(NWORDS);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic acc, clr;
  always_comb begin
    acc = in_valid & in_ready;
    clr = start & (state == IDLE | state == DONE);
    nxt = clr ? LOAD :
          state == LOAD ? ((acc && cnt == LAST) ? DRAIN : LOAD) :
          state == DRAIN ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      WEN <= 1'b1;
      CEN <= 1'b1;
      D <= '0;
      wr_blk <= '0;
      wr_addr <= '0;
      checksum <= '0;
    end else begin
      state <= nxt;
      in_ready <= nxt == LOAD;
      busy <= nxt == LOAD || nxt == DRAIN;
      done <= nxt == DONE;
      WEN <= ~acc;
      CEN <= ~acc;
      if (acc) begin
        D <= in_data;
        {wr_blk, wr_addr} <= cnt;
        cnt <= cnt + 1'b1;
        checksum <= checksum + 16'(in_data);
      end else if (clr) begin
        cnt <= '0;
        checksum <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cmem_loader.sv
// tb_cmem_loader: table-driven loads plus reset/ignored-control sequences, checked against a spec-level model and write scoreboard
module tb_cmem_loader;
  localparam int ID = 0, LD = 1, DR = 2, DN = 3;
  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [15:0] in_data, D, checksum;
  logic in_ready, WEN, CEN, busy, done;
  logic [2:0] wr_blk;
  logic [5:0] wr_addr;
  int total = 0, bad = 0, nwr = 0;
  int m_st = ID, m_cnt = 0;
  logic [15:0] m_sum = '0;
  logic e_wen = 1'b1;
  logic [24:0] exp_q[$];
  logic [15:0] mem [512];
  typedef struct {
    string name;
    int pct;
    bit ramp;
    int start_at;
    bit use_model;
  } vec_t;
  vec_t tv[4];

  cmem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .D(D), .WEN(WEN), .CEN(CEN), .wr_blk(wr_blk), .wr_addr(wr_addr),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_st <= ID;
      m_cnt <= 0;
      m_sum <= '0;
      e_wen <= 1'b1;
    end else begin
      e_wen <= !(in_valid && m_st == LD);
      if (in_valid && m_st == LD) begin
        exp_q.push_back({m_cnt[8:0], in_data});
        m_cnt <= m_cnt + 1;
        m_sum <= m_sum + in_data;
        if (m_cnt == 511) m_st <= DR;
      end else if (m_st == DR) m_st <= DN;
      else if ((m_st == ID || m_st == DN) && start) begin
        m_st <= LD;
        m_cnt <= 0;
        m_sum <= '0;
      end
    end
  end

  always @(posedge clk) if (!WEN && !CEN) mem[{wr_blk, wr_addr}] <= D;

  always @(negedge clk) begin
    chk("wen", WEN, e_wen);
    chk("cen", CEN, e_wen);
    chk("in_ready", in_ready, m_st == LD);
    chk("busy", busy, m_st == LD || m_st == DR);
    chk("done", done, m_st == DN);
    chk("checksum", checksum, m_sum);
    if (!WEN) begin
      nwr++;
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else chk("write_word", {wr_blk, wr_addr, D}, exp_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(int pct, bit ramp, int start_at, int stop_at);
    int n = 0;
    while (m_st == LD && m_cnt < stop_at && n < 20000) begin
      in_valid = $urandom_range(99) < pct;
      in_data = ramp ? 16'(m_cnt) : 16'($urandom);
      start = m_cnt == start_at;
      tick();
      n++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (n >= 20000) chk("feed_timeout", n, 0);
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_wen_cen"}, {WEN, CEN}, 2'b11);
    chk({nm, "_ready_busy_done"}, {in_ready, busy, done}, 3'b000);
    chk({nm, "_checksum"}, checksum, 16'h0000);
    chk({nm, "_d_blk_addr"}, {D, wr_blk, wr_addr}, 25'h0);
  endtask

  initial begin
    tv[0] = '{"full", 100, 1'b1, -1, 1'b0};
    tv[1] = '{"bubble", 50, 1'b0, -1, 1'b1};
    tv[2] = '{"start_mid", 100, 1'b1, 200, 1'b0};
    tv[3] = '{"bubble_ramp", 70, 1'b1, -1, 1'b0};
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 16'hABCD;
    repeat (2) tick();
    chk_reset_vals("reset");
    chk("reset_nowrite", nwr, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_nowrite", nwr, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nwr = 0;
      pulse_start();
      chk({tv[i].name, "_first_ready"}, {in_ready, busy, done}, 3'b110);
      feed(tv[i].pct, tv[i].ramp, tv[i].start_at, 512);
      repeat (3) tick();
      chk({tv[i].name, "_writes"}, nwr, 512);
      chk({tv[i].name, "_done"}, {done, busy}, 2'b10);
      chk({tv[i].name, "_sum"}, checksum, tv[i].use_model ? m_sum : 16'hFF00);
      if (tv[i].ramp)
        for (int k = 0; k < 8; k++) begin
          int a = k * 64 + $urandom_range(63);
          chk("readback", mem[a], a);
        end
    end
    nwr = 0;
    in_valid = 1'b1;
    repeat (3) tick();
    chk("done_nowrite", nwr, 0);
    in_valid = 1'b0;
    pulse_start();
    chk("restart_done_low", {done, in_ready}, 2'b01);
    chk("restart_sum_clr", checksum, 16'h0000);
    in_data = 16'h1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("restart_first_write", {WEN, wr_blk, wr_addr, D}, {1'b0, 9'd0, 16'h1234});
    feed(100, 1'b0, -1, 100);
    chk("midload_count", m_cnt, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("midload_rst");
    nwr = 0;
    pulse_start();
    feed(60, 1'b0, -1, 512);
    repeat (3) tick();
    chk("after_rst_writes", nwr, 512);
    chk("after_rst_done", done, 1'b1);
    chk("after_rst_sum", checksum, m_sum);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
